// File: rtl/adcbuf_capture.sv
// Multi-channel ADC capture: selects one AXI-stream channel, decimates, packs
// PACK samples per BRAM word and writes them in one-shot or ring mode.
module adcbuf_capture #(
  parameter int NCH                  = 2,
  parameter int ADC_AXIS_DATAWIDTH   = 64,
  parameter int BRAMTOHOST_DATAWIDTH = 256,
  parameter int BRAMTOHOST_ADDRWIDTH = 12,
  parameter int DECIMWIDTH           = 8,
  parameter int CHSELWIDTH           = 1
) (
  input  logic                                aclk,
  input  logic                                aresetn,
  input  logic [NCH*ADC_AXIS_DATAWIDTH-1:0]   s_axis_tdata,
  input  logic [NCH-1:0]                      s_axis_tvalid,
  output logic [NCH-1:0]                      s_axis_tready,
  input  logic [CHSELWIDTH-1:0]               chsel,
  input  logic                                mode,
  input  logic [DECIMWIDTH-1:0]               decim,
  input  logic                                trig_en,
  input  logic                                trig,
  input  logic                                start,
  input  logic                                stop,
  output logic                                bram_we,
  output logic [BRAMTOHOST_ADDRWIDTH-1:0]     bram_addr,
  output logic [BRAMTOHOST_DATAWIDTH-1:0]     bram_wdata,
  output logic                                busy,
  output logic                                done,
  output logic                                wrapped,
  output logic [BRAMTOHOST_ADDRWIDTH-1:0]     wptr
);
  localparam int ADCW = ADC_AXIS_DATAWIDTH;
  localparam int AW   = BRAMTOHOST_ADDRWIDTH;
  localparam int PACK = BRAMTOHOST_DATAWIDTH / ADCW;
  localparam int LW   = (PACK > 1) ? $clog2(PACK) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_CAPT, S_DONE} state_t;

  state_t                      state_q, state_d;
  logic [CHSELWIDTH-1:0]       chsel_q, chsel_d;
  logic                        mode_q, mode_d;
  logic [DECIMWIDTH-1:0]       decim_q, decim_d;
  logic                        trig_en_q, trig_en_d;
  logic [DECIMWIDTH-1:0]       dcnt_q, dcnt_d;
  logic [LW-1:0]               lane_q, lane_d;
  logic [PACK-1:0][ADCW-1:0]   pack_q, pack_d;
  logic [AW-1:0]               wptr_q, wptr_d;
  logic                        wrapped_q, wrapped_d;
  logic                        we_q, we_d;
  logic [AW-1:0]               addr_q, addr_d;
  logic [BRAMTOHOST_DATAWIDTH-1:0] wdata_q, wdata_d;

  logic [CHSELWIDTH-1:0]       sel;
  logic [ADCW-1:0]             sample;

  // No backpressure: every channel is always drained while out of reset.
  assign s_axis_tready = {NCH{aresetn}};

  assign sel    = (int'(chsel_q) < NCH) ? chsel_q : '0;
  assign sample = s_axis_tdata[sel*ADCW +: ADCW];

  always_comb begin
    state_d   = state_q;
    chsel_d   = chsel_q;
    mode_d    = mode_q;
    decim_d   = decim_q;
    trig_en_d = trig_en_q;
    dcnt_d    = dcnt_q;
    lane_d    = lane_q;
    pack_d    = pack_q;
    wptr_d    = wptr_q;
    wrapped_d = wrapped_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_ARM;
          chsel_d   = chsel;
          mode_d    = mode;
          decim_d   = decim;
          trig_en_d = trig_en;
          wptr_d    = '0;
          wrapped_d = 1'b0;
          lane_d    = '0;
          dcnt_d    = '0;
        end
      end
      S_ARM: begin
        if (stop)                    state_d = S_IDLE;
        else if (!trig_en_q || trig) state_d = S_CAPT;
      end
      S_CAPT: begin
        if (s_axis_tvalid[sel]) begin
          dcnt_d = (dcnt_q == decim_q) ? '0 : dcnt_q + 1'b1;
          if (dcnt_q == '0) begin
            pack_d[lane_q] = sample;
            if (lane_q == LW'(PACK-1)) begin
              // Word completes this cycle; it is written even if stop is also high.
              we_d    = 1'b1;
              addr_d  = wptr_q;
              wdata_d = pack_d;
              lane_d  = '0;
              wptr_d  = wptr_q + 1'b1;
              if (&wptr_q) begin
                if (mode_q) wrapped_d = 1'b1;
                else        state_d   = S_DONE;
              end
            end else begin
              lane_d = lane_q + 1'b1;
            end
          end
        end
        if (stop) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= S_IDLE;
      chsel_q   <= '0;
      mode_q    <= 1'b0;
      decim_q   <= '0;
      trig_en_q <= 1'b0;
      dcnt_q    <= '0;
      lane_q    <= '0;
      pack_q    <= '0;
      wptr_q    <= '0;
      wrapped_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      chsel_q   <= chsel_d;
      mode_q    <= mode_d;
      decim_q   <= decim_d;
      trig_en_q <= trig_en_d;
      dcnt_q    <= dcnt_d;
      lane_q    <= lane_d;
      pack_q    <= pack_d;
      wptr_q    <= wptr_d;
      wrapped_q <= wrapped_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign bram_we    = we_q;
  assign bram_addr  = addr_q;
  assign bram_wdata = wdata_q;
  assign wptr       = wptr_q;
  assign wrapped    = wrapped_q;
  assign busy       = (state_q == S_ARM) || (state_q == S_CAPT);
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_adcbuf_capture.sv
// Directed-sequence bench with random data; expected BRAM writes are derived
// from the recorded sample stream and the capture window of each run.
module tb_adcbuf_capture;
  localparam int NCH = 2, ADCW = 64, BW = 256, AW = 4, DW = 8, CW = 1;
  localparam int PACK = BW / ADCW;
  localparam int NEVER = 1 << 30;

  logic                 aclk = 1'b0;
  logic                 aresetn = 1'b0;
  logic [NCH*ADCW-1:0]  s_axis_tdata = '0;
  logic [NCH-1:0]       s_axis_tvalid = '0;
  logic [NCH-1:0]       s_axis_tready;
  logic [CW-1:0]        chsel = '0;
  logic                 mode = 1'b0;
  logic [DW-1:0]        decim = '0;
  logic                 trig_en = 1'b0;
  logic                 trig = 1'b0;
  logic                 start = 1'b0;
  logic                 stop = 1'b0;
  logic                 bram_we;
  logic [AW-1:0]        bram_addr;
  logic [BW-1:0]        bram_wdata;
  logic                 busy, done, wrapped;
  logic [AW-1:0]        wptr;

  adcbuf_capture #(
    .NCH(NCH), .ADC_AXIS_DATAWIDTH(ADCW), .BRAMTOHOST_DATAWIDTH(BW),
    .BRAMTOHOST_ADDRWIDTH(AW), .DECIMWIDTH(DW), .CHSELWIDTH(CW)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .chsel(chsel), .mode(mode), .decim(decim), .trig_en(trig_en), .trig(trig),
    .start(start), .stop(stop),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
    .busy(busy), .done(done), .wrapped(wrapped), .wptr(wptr)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  typedef struct { int e; logic [ADCW-1:0] d; } samp_t;
  typedef struct { int e; logic [AW-1:0] a; logic [BW-1:0] d; } wr_t;
  samp_t sq[$];
  wr_t   got[$];
  wr_t   mon_w;

  // Writes are logged with the index of the edge that accepted the completing sample.
  always @(negedge aclk) begin
    if (aresetn && bram_we) begin
      mon_w.e = cyc; mon_w.a = bram_addr; mon_w.d = bram_wdata;
      got.push_back(mon_w);
    end
  end

  int ntests = 0, nfail = 0;

  task automatic chk(input string tag, input logic [BW-1:0] o, input logic [BW-1:0] e);
    ntests++;
    assert (o === e) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  // One clock of stimulus; the selected channel carries d/v, the other channel is noise.
  task automatic cyc1(input bit st, input bit sp, input bit tg, input bit v, input logic [ADCW-1:0] d);
    samp_t s;
    @(negedge aclk);
    start = st; stop = sp; trig = tg;
    s_axis_tdata  = {$urandom, $urandom, $urandom, $urandom};
    s_axis_tvalid = NCH'($urandom);
    s_axis_tdata[chsel*ADCW +: ADCW] = d;
    s_axis_tvalid[chsel] = v;
    if (v) begin s.e = cyc + 1; s.d = d; sq.push_back(s); end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc1(0, 0, 0, 0, '0);
  endtask

  // Reference: valid samples inside [open_e, close_e], keep every (dec+1)-th,
  // group PACK at a time; one-shot stops after 2^AW words.
  task automatic check_run(input string tag, input bit m, input int dec, input int open_e, input int close_e);
    wr_t exp[$];
    wr_t w;
    logic [BW-1:0] acc = '0;
    int n = 0, k = 0, words = 0, lim;
    foreach (sq[i]) begin
      if (sq[i].e >= open_e && sq[i].e <= close_e && !(m == 1'b0 && words == (1 << AW))) begin
        if (n % (dec + 1) == 0) begin
          acc[k*ADCW +: ADCW] = sq[i].d;
          k++;
          if (k == PACK) begin
            w.e = sq[i].e; w.a = AW'(words); w.d = acc;
            exp.push_back(w);
            words++; k = 0;
          end
        end
        n++;
      end
    end
    chk({tag, ".nwrites"}, got.size(), exp.size());
    lim = (got.size() < exp.size()) ? got.size() : exp.size();
    for (int i = 0; i < lim; i++) begin
      chk($sformatf("%s.addr[%0d]", tag, i), got[i].a, exp[i].a);
      chk($sformatf("%s.data[%0d]", tag, i), got[i].d, exp[i].d);
      chk($sformatf("%s.cycle[%0d]", tag, i), got[i].e, exp[i].e);
    end
    chk({tag, ".wptr"}, wptr, words % (1 << AW));
    chk({tag, ".wrapped"}, wrapped, (m && words >= (1 << AW)) ? 1 : 0);
    chk({tag, ".done"}, done, 1);
    chk({tag, ".busy"}, busy, 0);
    sq.delete(); got.delete();
  endtask

  task automatic oneshot_ramp(input string tag, input logic [CW-1:0] ch);
    int s_e;
    logic [ADCW-1:0] r = '0;
    chsel = ch; mode = 1'b0; decim = '0; trig_en = 1'b0;
    cyc1(1, 0, 0, 1, r); s_e = cyc + 1;
    for (int i = 0; i < 75; i++) begin r = r + 1; cyc1(0, 0, 0, 1, r); end
    idle(3);
    check_run(tag, 0, 0, s_e + 2, NEVER);
  endtask

  initial begin
    int s_e, t_e, p_e, dec;

    // Reset state
    repeat (3) @(negedge aclk);
    chk("rst.tready", s_axis_tready, 0);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.we", bram_we, 0);
    chk("rst.wptr", wptr, 0);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("run.tready", s_axis_tready, {NCH{1'b1}});
    chk("idle.busy", busy, 0);

    // One-shot ramp on channel 1: 16 words then DONE, wptr back at 0
    oneshot_ramp("oneshot", 1);

    // Decimation by 3 with tvalid toggling, one-shot stopped early
    chsel = 0; mode = 0; decim = 8'd2; trig_en = 0;
    cyc1(1, 0, 0, 0, '0); s_e = cyc + 1;
    for (int i = 0; i < 60; i++) cyc1(0, 0, 0, i[0], {$urandom, $urandom});
    cyc1(0, 1, 0, 1, {$urandom, $urandom}); p_e = cyc + 1;
    idle(3);
    check_run("decim", 0, 2, s_e + 2, p_e);

    // Hardware trigger after 50 cycles in ARM, continuous mode
    chsel = 1; mode = 1; decim = 0; trig_en = 1;
    cyc1(1, 0, 0, 1, {$urandom, $urandom});
    for (int i = 1; i < 50; i++) cyc1(0, 0, 0, 1, {$urandom, $urandom});
    cyc1(0, 0, 1, 1, {$urandom, $urandom}); t_e = cyc + 1;
    for (int i = 0; i < 30; i++) cyc1(0, 0, 0, 1, {$urandom, $urandom});
    cyc1(0, 1, 0, 0, '0); p_e = cyc + 1;
    idle(3);
    check_run("trig", 1, 0, t_e + 1, p_e);

    // Continuous wrap: 20 full words plus a partial, stray start mid-capture
    chsel = 0; mode = 1; decim = 0; trig_en = 0;
    cyc1(1, 0, 0, 1, {$urandom, $urandom}); s_e = cyc + 1;
    for (int i = 0; i < 82; i++) cyc1(i == 30, 0, 0, 1, {$urandom, $urandom});
    cyc1(0, 1, 0, 0, '0); p_e = cyc + 1;
    idle(3);
    chk("wrap.wptr4", wptr, 4);
    check_run("wrap", 1, 0, s_e + 2, p_e);

    // Stop while armed: back to IDLE, nothing written
    chsel = 1; trig_en = 1;
    cyc1(1, 0, 0, 1, {$urandom, $urandom});
    for (int i = 0; i < 5; i++) cyc1(0, 0, 0, 1, {$urandom, $urandom});
    cyc1(0, 1, 0, 1, {$urandom, $urandom});
    idle(3);
    chk("armstop.busy", busy, 0);
    chk("armstop.done", done, 0);
    chk("armstop.nwrites", got.size(), 0);
    sq.delete(); got.delete();

    // Random channel, decimation and valid pattern in ring mode
    for (int r = 0; r < 2; r++) begin
      dec = $urandom_range(0, 3);
      chsel = CW'($urandom); mode = 1; decim = DW'(dec); trig_en = 0;
      cyc1(1, 0, 0, 1, {$urandom, $urandom}); s_e = cyc + 1;
      for (int i = 0; i < 150; i++) cyc1(0, 0, 0, 1'($urandom), {$urandom, $urandom});
      cyc1(0, 1, 0, 1'($urandom), {$urandom, $urandom}); p_e = cyc + 1;
      idle(3);
      check_run($sformatf("rand%0d", r), 1, dec, s_e + 2, p_e);
    end

    // Asynchronous reset in the middle of a one-shot capture
    chsel = 0; mode = 0; decim = 0; trig_en = 0;
    cyc1(1, 0, 0, 1, {$urandom, $urandom});
    for (int i = 0; i < 31; i++) cyc1(0, 0, 0, 1, {$urandom, $urandom});
    chk("midrst.prebusy", busy, 1);
    chk("midrst.prewptr", wptr, 7);
    @(negedge aclk);
    start = 0; stop = 0;
    #2 aresetn = 1'b0;
    #1;
    chk("midrst.tready", s_axis_tready, 0);
    chk("midrst.busy", busy, 0);
    chk("midrst.we", bram_we, 0);
    chk("midrst.addr", bram_addr, 0);
    chk("midrst.wdata", bram_wdata, 0);
    chk("midrst.wptr", wptr, 0);
    chk("midrst.wrapped", wrapped, 0);
    chk("midrst.done", done, 0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    sq.delete(); got.delete();
    oneshot_ramp("fresh", 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
